// File: rtl/rv_cache_assoc_if.sv
// Core load/store port and slave bus signals of rv_cache_assoc, grouped as one bundle.
// slave = the cache side, master = the core plus bus agent that drives it.
`ifndef SLAVE_SEL_WIDTH
`define SLAVE_SEL_WIDTH 4
`endif

interface rv_cache_assoc_if;
  logic [31:0] i_addr;
  logic        i_read;
  logic        i_write;
  logic [3:0]  i_write_sel;
  logic [31:0] i_write_data;
  logic        i_flush;
  logic [31:0] o_data;
  logic        o_ack;
  logic [31:0] o_bus_addr;
  logic        o_bus_read;
  logic        o_bus_write;
  logic [3:0]  o_bus_sel;
  logic [31:0] o_bus_data;
  logic [31:0] i_bus_data;
  logic        i_bus_ack;

  modport slave (
    input  i_addr, i_read, i_write, i_write_sel, i_write_data, i_flush,
    input  i_bus_data, i_bus_ack,
    output o_data, o_ack, o_bus_addr, o_bus_read, o_bus_write, o_bus_sel, o_bus_data
  );

  modport master (
    output i_addr, i_read, i_write, i_write_sel, i_write_data, i_flush,
    output i_bus_data, i_bus_ack,
    input  o_data, o_ack, o_bus_addr, o_bus_read, o_bus_write, o_bus_sel, o_bus_data
  );
endinterface

// File: rtl/rv_cache_assoc.sv
// N-way set-associative write-through / no-write-allocate cache with line refill FSM,
// non-cacheable pass-through and read hit/miss counters.
`ifndef SLAVE_SEL_WIDTH
`define SLAVE_SEL_WIDTH 4
`endif

module rv_cache_assoc #(
  parameter int unsigned                  WAY_COUNT_BIT = 1,
  parameter int unsigned                  LINE_SIZE_BIT = 2,
  parameter int unsigned                  SET_COUNT_BIT = 3,
  parameter logic [`SLAVE_SEL_WIDTH-1:0]  ADDR_HI       = '0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  rv_cache_assoc_if.slave    bus,
  output logic [31:0]        o_hit_count,
  output logic [31:0]        o_miss_count
);

  localparam int unsigned SSW   = `SLAVE_SEL_WIDTH;
  localparam int unsigned WAYS  = 1 << WAY_COUNT_BIT;
  localparam int unsigned WORDS = 1 << LINE_SIZE_BIT;
  localparam int unsigned SETS  = 1 << SET_COUNT_BIT;
  localparam int unsigned TAG_W = 32 - SSW - 2 - LINE_SIZE_BIT - SET_COUNT_BIT;
  localparam int unsigned WW    = (WAY_COUNT_BIT > 0) ? WAY_COUNT_BIT : 1;
  localparam int unsigned LW    = (LINE_SIZE_BIT > 0) ? LINE_SIZE_BIT : 1;
  localparam logic [LW-1:0] LAST_WORD = LW'(WORDS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_BYPASS = 2'd3;

  logic [1:0]               r_state;
  logic [LW-1:0]            r_cnt;
  logic [WW-1:0]            r_vway;
  logic                     r_vic_from_ptr;
  logic                     r_fill_done;
  logic [31:0]              r_hit_count;
  logic [31:0]              r_miss_count;
  logic                     r_bus_read;
  logic                     r_bus_write;
  logic [31:0]              r_bus_addr;
  logic [3:0]               r_bus_sel;
  logic [31:0]              r_bus_data;
  logic [SETS-1:0]          r_valid [WAYS];
  logic [WW-1:0]            r_ptr   [SETS];
  logic [TAG_W-1:0]         r_tag   [WAYS][SETS];
  logic [31:0]              r_data  [WAYS][SETS][WORDS];

  logic                     w_cacheable;
  logic [TAG_W-1:0]         w_tag;
  logic [SET_COUNT_BIT-1:0] w_set;
  logic [LW-1:0]            w_word;
  logic [31:0]              w_line_base;
  logic                     w_hit;
  logic [WW-1:0]            w_hit_way;
  logic [31:0]              w_hit_data;
  logic                     w_free;
  logic [WW-1:0]            w_free_way;
  logic [WW-1:0]            w_ptr_next;
  logic                     w_ack;
  logic [31:0]              w_rdata;
  logic                     w_refill_we;
  logic                     w_write_hit;

  assign w_cacheable = (bus.i_addr[31 -: SSW] == ADDR_HI);
  assign w_tag       = bus.i_addr[31-SSW -: TAG_W];
  assign w_set       = bus.i_addr[2+LINE_SIZE_BIT +: SET_COUNT_BIT];
  assign w_line_base = bus.i_addr & ~(32'(WORDS * 4) - 32'd1);

  always_comb begin
    w_word = '0;
    if (LINE_SIZE_BIT != 0) w_word = bus.i_addr[2 +: LW];
  end

  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_free     = 1'b0;
    w_free_way = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!w_hit && r_valid[i][w_set] && (r_tag[i][w_set] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(i);
      end
      if (!w_free && !r_valid[i][w_set]) begin
        w_free     = 1'b1;
        w_free_way = WW'(i);
      end
    end
  end

  assign w_hit_data  = r_data[w_hit_way][w_set][w_word];
  assign w_ptr_next  = (r_ptr[w_set] == WW'(WAYS - 1)) ? '0 : r_ptr[w_set] + 1'b1;
  assign w_refill_we = (r_state == S_REFILL) && bus.i_bus_ack;
  assign w_write_hit = (r_state == S_IDLE) && !bus.i_flush && !bus.i_read && bus.i_write &&
                       w_cacheable && w_hit;

  always_comb begin
    w_ack   = 1'b0;
    w_rdata = w_hit_data;
    case (r_state)
      S_IDLE:   w_ack = !bus.i_flush && bus.i_read && w_cacheable && w_hit;
      S_WRITE:  w_ack = bus.i_bus_ack;
      S_BYPASS: begin
        w_ack   = bus.i_bus_ack;
        w_rdata = bus.i_bus_data;
      end
      default:  w_ack = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_vway         <= '0;
      r_vic_from_ptr <= 1'b0;
      r_fill_done    <= 1'b0;
      r_hit_count    <= '0;
      r_miss_count   <= '0;
      r_bus_read     <= 1'b0;
      r_bus_write    <= 1'b0;
      r_bus_addr     <= '0;
      r_bus_sel      <= '0;
      r_bus_data     <= '0;
      for (int unsigned i = 0; i < WAYS; i++) r_valid[i] <= '0;
      for (int unsigned s = 0; s < SETS; s++) r_ptr[s] <= '0;
    end else begin
      r_fill_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_flush) begin
            for (int unsigned i = 0; i < WAYS; i++) r_valid[i] <= '0;
          end else if (bus.i_read) begin
            if (w_cacheable) begin
              // The hit that completes a refilled request is not a real hit.
              if (w_hit) begin
                if (!r_fill_done) r_hit_count <= r_hit_count + 32'd1;
              end else begin
                r_vway         <= w_free ? w_free_way : r_ptr[w_set];
                r_vic_from_ptr <= !w_free;
                if (!w_free) r_valid[r_ptr[w_set]][w_set] <= 1'b0;
                r_cnt          <= '0;
                r_miss_count   <= r_miss_count + 32'd1;
                r_bus_read     <= 1'b1;
                r_bus_addr     <= w_line_base;
                r_bus_sel      <= 4'hF;
                r_state        <= S_REFILL;
              end
            end else begin
              r_bus_read <= 1'b1;
              r_bus_addr <= bus.i_addr;
              r_bus_sel  <= 4'hF;
              r_state    <= S_BYPASS;
            end
          end else if (bus.i_write) begin
            r_bus_write <= 1'b1;
            r_bus_addr  <= bus.i_addr;
            r_bus_sel   <= bus.i_write_sel;
            r_bus_data  <= bus.i_write_data;
            r_state     <= S_WRITE;
          end
        end
        S_REFILL: begin
          if (bus.i_bus_ack) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_WORD) begin
              r_valid[r_vway][w_set] <= 1'b1;
              if (r_vic_from_ptr) r_ptr[w_set] <= w_ptr_next;
              r_bus_read  <= 1'b0;
              r_fill_done <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_bus_addr <= r_bus_addr + 32'd4;
            end
          end
        end
        S_WRITE: begin
          if (bus.i_bus_ack) begin
            r_bus_write <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          if (bus.i_bus_ack) begin
            r_bus_read <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_refill_we) begin
      r_data[r_vway][w_set][r_cnt] <= bus.i_bus_data;
      if (r_cnt == LAST_WORD) r_tag[r_vway][w_set] <= w_tag;
    end else if (w_write_hit) begin
      for (int unsigned b = 0; b < 4; b++)
        if (bus.i_write_sel[b]) r_data[w_hit_way][w_set][w_word][8*b +: 8] <= bus.i_write_data[8*b +: 8];
    end
  end

  assign bus.o_data      = w_rdata;
  assign bus.o_ack       = w_ack;
  assign bus.o_bus_addr  = r_bus_addr;
  assign bus.o_bus_read  = r_bus_read;
  assign bus.o_bus_write = r_bus_write;
  assign bus.o_bus_sel   = r_bus_sel;
  assign bus.o_bus_data  = r_bus_data;
  assign o_hit_count     = r_hit_count;
  assign o_miss_count    = r_miss_count;

endmodule

// File: tb/tb_rv_cache_assoc.sv
// Scoreboard bench for rv_cache_assoc: directed requests queue expected acks and bus
// transfers, negedge monitors pop and compare them.
module tb_rv_cache_assoc;
  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] o_hit_count;
  logic [31:0] o_miss_count;

  rv_cache_assoc_if cif ();

  rv_cache_assoc #(
    .WAY_COUNT_BIT (1),
    .LINE_SIZE_BIT (2),
    .SET_COUNT_BIT (3),
    .ADDR_HI       (4'h0)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .bus          (cif),
    .o_hit_count  (o_hit_count),
    .o_miss_count (o_miss_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic rd; logic [31:0] data; } ack_t;
  typedef struct { logic wr; logic [31:0] addr; logic [3:0] sel; logic [31:0] data; } bus_t;

  ack_t ack_q[$];
  bus_t bus_q[$];
  ack_t mon_a;
  bus_t mon_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h9C + (a >> 2);
  endfunction

  // Bus agent: acks one cycle after seeing a strobe, then idles one cycle.
  initial begin
    cif.i_bus_ack  = 1'b0;
    cif.i_bus_data = '0;
    forever begin
      @(posedge i_clk);
      #1;
      if (cif.i_bus_ack) cif.i_bus_ack = 1'b0;
      else if (cif.o_bus_read || cif.o_bus_write) begin
        cif.i_bus_ack  = 1'b1;
        cif.i_bus_data = cif.o_bus_read ? mem_word(cif.o_bus_addr) : 32'h0;
      end
    end
  end

  always @(negedge i_clk) begin
    if (!i_reset && cif.o_ack) begin
      n_checks++;
      if (ack_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: got ack with addr %h, required none", cif.i_addr);
      end else begin
        n_checks--;
        mon_a = ack_q.pop_front();
        check("ack_kind_is_read", {31'b0, cif.i_read}, {31'b0, mon_a.rd});
        if (mon_a.rd) check("read_data", cif.o_data, mon_a.data);
      end
    end
    if (!i_reset && cif.i_bus_ack && (cif.o_bus_read || cif.o_bus_write)) begin
      n_checks++;
      if (bus_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_bus: got transfer at %h, required none", cif.o_bus_addr);
      end else begin
        n_checks--;
        mon_b = bus_q.pop_front();
        check("bus_is_write", {31'b0, cif.o_bus_write}, {31'b0, mon_b.wr});
        check("bus_addr", cif.o_bus_addr, mon_b.addr);
        check("bus_sel", {28'b0, cif.o_bus_sel}, {28'b0, mon_b.sel});
        if (mon_b.wr) check("bus_wdata", cif.o_bus_data, mon_b.data);
      end
    end
  end

  task automatic expect_refill(input logic [31:0] base);
    for (int k = 0; k < 4; k++) bus_q.push_back('{1'b0, base + 32'(4 * k), 4'hF, 32'h0});
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    forever begin
      @(negedge i_clk);
      if (cif.o_ack) break;
      lat++;
      if (lat > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL ack_timeout: got no ack in 100 cycles, required ack");
        break;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input int exp_lat);
    int lat;
    ack_q.push_back('{1'b1, exp});
    cif.i_addr = addr;
    cif.i_read = 1'b1;
    wait_ack(lat);
    cif.i_read = 1'b0;
    if (exp_lat >= 0) check("hit_latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    int lat;
    ack_q.push_back('{1'b0, 32'h0});
    bus_q.push_back('{1'b1, addr, sel, data});
    cif.i_addr       = addr;
    cif.i_write_data = data;
    cif.i_write_sel  = sel;
    cif.i_write      = 1'b1;
    wait_ack(lat);
    cif.i_write = 1'b0;
  endtask

  task automatic check_counts(input logic [31:0] hits, input logic [31:0] misses);
    check("hit_count", o_hit_count, hits);
    check("miss_count", o_miss_count, misses);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    i_reset          = 1'b1;
    cif.i_addr       = '0;
    cif.i_read       = 1'b0;
    cif.i_write      = 1'b0;
    cif.i_write_sel  = '0;
    cif.i_write_data = '0;
    cif.i_flush      = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_ack", {31'b0, cif.o_ack}, 32'h0);
    check("rst_bus_read", {31'b0, cif.o_bus_read}, 32'h0);
    check("rst_bus_write", {31'b0, cif.o_bus_write}, 32'h0);
    check("rst_bus_addr", cif.o_bus_addr, 32'h0);
    check("rst_bus_sel", {28'b0, cif.o_bus_sel}, 32'h0);
    check_counts(0, 0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    expect_refill(32'h10);
    do_read(32'h10, 32'hA0, -1);
    check_counts(0, 1);
    do_read(32'h18, 32'hA2, 0);
    check_counts(1, 1);
    do_write(32'h18, 32'hDEAD_BEEF, 4'b0011);
    check_counts(1, 1);
    do_read(32'h18, 32'h0000_BEEF, 0);
    check_counts(2, 1);

    expect_refill(32'h000);
    do_read(32'h000, 32'h9C, -1);
    expect_refill(32'h080);
    do_read(32'h080, 32'hBC, -1);
    expect_refill(32'h100);
    do_read(32'h100, 32'hDC, -1);
    check_counts(2, 4);
    do_read(32'h080, 32'hBC, 0);
    expect_refill(32'h000);
    do_read(32'h000, 32'h9C, -1);
    do_read(32'h100, 32'hDC, 0);
    check_counts(4, 5);

    bus_q.push_back('{1'b0, 32'h1000_0040, 4'hF, 32'h0});
    do_read(32'h1000_0040, 32'h0400_00AC, -1);
    bus_q.push_back('{1'b0, 32'h1000_0040, 4'hF, 32'h0});
    do_read(32'h1000_0040, 32'h0400_00AC, -1);
    check_counts(4, 5);

    bus_q.push_back('{1'b0, 32'h220, 4'hF, 32'h0});
    bus_q.push_back('{1'b0, 32'h224, 4'hF, 32'h0});
    cif.i_addr = 32'h220;
    cif.i_read = 1'b1;
    n = 0;
    forever begin
      @(negedge i_clk);
      if (cif.o_bus_read && cif.o_bus_addr == 32'h228 && !cif.i_bus_ack) break;
      n++;
      if (n > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL third_word_timeout: got no third refill strobe, required one");
        break;
      end
    end
    i_reset = 1'b1;
    #1;
    check("mid_rst_bus_read", {31'b0, cif.o_bus_read}, 32'h0);
    check("mid_rst_ack", {31'b0, cif.o_ack}, 32'h0);
    check_counts(0, 0);
    cif.i_read = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    expect_refill(32'h220);
    do_read(32'h220, 32'h124, -1);
    check_counts(0, 1);
    do_read(32'h224, 32'h125, 0);
    check_counts(1, 1);

    ack_q.push_back('{1'b1, 32'h124});
    expect_refill(32'h220);
    cif.i_addr  = 32'h220;
    cif.i_read  = 1'b1;
    cif.i_flush = 1'b1;
    @(negedge i_clk);
    check("flush_blocks_ack", {31'b0, cif.o_ack}, 32'h0);
    @(posedge i_clk);
    #1;
    cif.i_flush = 1'b0;
    wait_ack(lat);
    cif.i_read = 1'b0;
    check_counts(1, 2);

    repeat (4) @(posedge i_clk);
    check("ack_queue_drained", 32'(ack_q.size()), 32'h0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
